// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB responder: FSM states, read-only
// register locations and synchronizer depth.
package sccb_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    SUB,
    SUB_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_ACK,
    IGNORE
  } sccb_state_t;

  localparam logic [7:0] REG_PID_ADDR = 8'h0A;
  localparam logic [7:0] REG_VER_ADDR = 8'h0B;
  localparam int         SYNC_STAGES  = 2;

  function automatic logic is_read_only(input logic [7:0] addr);
    return (addr == REG_PID_ADDR) || (addr == REG_VER_ADDR);
  endfunction

endpackage

// File: rtl/sccb_bus_monitor.sv
// Synchronizes SCL/SDA to clk and emits registered one-cycle SCL edge and
// START/STOP pulses, plus the SDA level aligned with those pulses.
module sccb_bus_monitor
  import sccb_pkg::*;
(
  input  logic clk,
  input  logic reset_,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o,
  output logic sda_o
);

  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic scl_dly_q, sda_dly_q;
  logic scl_s, sda_s;
  logic scl_rise_d, scl_fall_d, start_d, stop_d;
  logic scl_rise_q, scl_fall_q, start_q, stop_q, sda_q;

  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];

  assign scl_rise_d = scl_s & ~scl_dly_q;
  assign scl_fall_d = ~scl_s & scl_dly_q;
  // SCL must be high on both sides of the SDA transition to count as START/STOP.
  assign start_d    = scl_s & scl_dly_q & ~sda_s & sda_dly_q;
  assign stop_d     = scl_s & scl_dly_q & sda_s & ~sda_dly_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset_) begin
    if (reset_) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_dly_q  <= 1'b1;
      sda_dly_q  <= 1'b1;
      scl_rise_q <= 1'b0;
      scl_fall_q <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      sda_q      <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_dly_q  <= scl_s;
      sda_dly_q  <= sda_s;
      scl_rise_q <= scl_rise_d;
      scl_fall_q <= scl_fall_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
      sda_q      <= sda_s;
    end
  end

  assign scl_rise_o = scl_rise_q;
  assign scl_fall_o = scl_fall_q;
  assign start_o    = start_q;
  assign stop_o     = stop_q;
  assign sda_o      = sda_q;

endmodule

// File: rtl/sccb_responder.sv
// OV7670-style SCCB target: decodes device address, sub-address and data
// bytes, serves a 256 x 8 register file with read-only PID/VER locations.
module sccb_responder
  import sccb_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR = 7'h21,
  parameter logic [7:0] PID_VAL  = 8'h76,
  parameter logic [7:0] VER_VAL  = 8'h73
) (
  input  logic       clk,
  input  logic       reset_,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       sda_oe,
  output logic       reg_wr_en,
  output logic [7:0] reg_wr_addr,
  output logic [7:0] reg_wr_data,
  output logic       busy,
  input  logic [7:0] dbg_addr,
  output logic [7:0] dbg_data
);

  sccb_state_t state_q;
  logic [2:0]  bit_cnt_q;
  logic [7:0]  shift_q, shift_d, ptr_q;
  logic        rw_q, ack_clk_q, mack_q;
  logic        sda_oe_q, busy_q, wr_en_q;
  logic [7:0]  wr_addr_q, wr_data_q;
  logic [7:0]  regs_q [256];

  logic scl_rise, scl_fall, start_det, stop_det, sda_smp;
  logic last_bit, wr_fire;

  sccb_bus_monitor u_mon (
    .clk        (clk),
    .reset_     (reset_),
    .scl_i      (scl_in),
    .sda_i      (sda_in),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_o    (start_det),
    .stop_o     (stop_det),
    .sda_o      (sda_smp)
  );

  function automatic logic [7:0] reg_reset_val(input logic [7:0] a);
    if (a == REG_PID_ADDR) return PID_VAL;
    if (a == REG_VER_ADDR) return VER_VAL;
    return 8'h00;
  endfunction

  assign shift_d  = {shift_q[6:0], sda_smp};
  assign last_bit = (bit_cnt_q == 3'd7);
  // Commit on the rising edge of the ACK clock that follows a data byte.
  assign wr_fire  = (state_q == WDATA_ACK) && scl_rise && !ack_clk_q && !start_det && !stop_det;

  // ack_clk_q marks that the 9th (ACK) clock has risen: the first SCL fall in
  // an ACK state starts the ACK slot, the second one ends it.
  always_ff @(posedge clk or posedge reset_) begin
    if (reset_) begin
      state_q   <= IDLE;
      bit_cnt_q <= 3'd0;
      shift_q   <= 8'h00;
      ptr_q     <= 8'h00;
      rw_q      <= 1'b0;
      ack_clk_q <= 1'b0;
      mack_q    <= 1'b1;
      sda_oe_q  <= 1'b0;
      busy_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= 8'h00;
      wr_data_q <= 8'h00;
    end else begin
      wr_en_q <= 1'b0;
      if (start_det) begin
        state_q   <= ADDR;
        bit_cnt_q <= 3'd0;
        sda_oe_q  <= 1'b0;
      end else if (stop_det) begin
        state_q  <= IDLE;
        busy_q   <= 1'b0;
        sda_oe_q <= 1'b0;
      end else begin
        case (state_q)
          ADDR: if (scl_rise) begin
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (last_bit) begin
              ack_clk_q <= 1'b0;
              if (shift_d[7:1] == DEV_ADDR) begin
                busy_q  <= 1'b1;
                rw_q    <= shift_d[0];
                state_q <= ADDR_ACK;
              end else begin
                busy_q  <= 1'b0;
                state_q <= IGNORE;
              end
            end
          end
          SUB: if (scl_rise) begin
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (last_bit) begin
              ack_clk_q <= 1'b0;
              ptr_q     <= shift_d;
              state_q   <= SUB_ACK;
            end
          end
          WDATA: if (scl_rise) begin
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (last_bit) begin
              ack_clk_q <= 1'b0;
              state_q   <= WDATA_ACK;
            end
          end
          ADDR_ACK, SUB_ACK, WDATA_ACK: begin
            if (scl_rise) begin
              ack_clk_q <= 1'b1;
              if (wr_fire) begin
                wr_en_q   <= 1'b1;
                wr_addr_q <= ptr_q;
                wr_data_q <= shift_q;
                ptr_q     <= ptr_q + 8'd1;
              end
            end else if (scl_fall) begin
              if (!ack_clk_q) begin
                sda_oe_q <= 1'b1;
              end else begin
                bit_cnt_q <= 3'd0;
                if (state_q == ADDR_ACK && rw_q) begin
                  state_q  <= RDATA;
                  shift_q  <= regs_q[ptr_q];
                  sda_oe_q <= ~regs_q[ptr_q][7];
                end else begin
                  sda_oe_q <= 1'b0;
                  state_q  <= (state_q == ADDR_ACK) ? SUB : WDATA;
                end
              end
            end
          end
          RDATA: begin
            if (scl_rise) begin
              bit_cnt_q <= bit_cnt_q + 3'd1;
              if (last_bit) begin
                ack_clk_q <= 1'b0;
                state_q   <= RDATA_ACK;
              end
            end else if (scl_fall) begin
              // bit_cnt_q rises already seen, so the next bit is 7 - bit_cnt_q.
              sda_oe_q <= ~shift_q[~bit_cnt_q];
            end
          end
          RDATA_ACK: begin
            if (scl_rise) begin
              ack_clk_q <= 1'b1;
              mack_q    <= sda_smp;
              ptr_q     <= ptr_q + 8'd1;
            end else if (scl_fall) begin
              if (!ack_clk_q) begin
                sda_oe_q <= 1'b0;
              end else if (mack_q) begin
                state_q <= IGNORE;
              end else begin
                state_q   <= RDATA;
                bit_cnt_q <= 3'd0;
                shift_q   <= regs_q[ptr_q];
                sda_oe_q  <= ~regs_q[ptr_q][7];
              end
            end
          end
          default: sda_oe_q <= 1'b0;
        endcase
      end
    end
  end

  // NOTE: the register file is reset on purpose -- reset must restore PID/VER and clear the rest.
  always_ff @(posedge clk or posedge reset_) begin
    if (reset_) begin
      for (int i = 0; i < 256; i++) regs_q[8'(i)] <= reg_reset_val(8'(i));
    end else if (wr_fire && !is_read_only(ptr_q)) begin
      regs_q[ptr_q] <= shift_q;
    end
  end

  assign sda_oe      = sda_oe_q;
  assign busy        = busy_q;
  assign reg_wr_en   = wr_en_q;
  assign reg_wr_addr = wr_addr_q;
  assign reg_wr_data = wr_data_q;
  assign dbg_data    = regs_q[dbg_addr];

endmodule

// File: tb/tb_sccb_responder.sv
// Bit-banged SCCB master driving the responder, checked against a
// transaction-level register/pointer model plus a table of fixed vectors.
module tb_sccb_responder;

  localparam int HALF = 10;

  logic       clk = 1'b0;
  logic       reset_ = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_bus;
  logic       sda_oe, reg_wr_en, busy;
  logic [7:0] reg_wr_addr, reg_wr_data, dbg_addr, dbg_data;

  assign sda_bus = sda_m & ~sda_oe;

  sccb_responder dut (
    .clk         (clk),
    .reset_      (reset_),
    .scl_in      (scl_m),
    .sda_in      (sda_bus),
    .sda_oe      (sda_oe),
    .reg_wr_en   (reg_wr_en),
    .reg_wr_addr (reg_wr_addr),
    .reg_wr_data (reg_wr_data),
    .busy        (busy),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  logic [15:0] wr_log[$];
  logic        oe_seen = 1'b0;

  always @(negedge clk) begin
    if (reg_wr_en) wr_log.push_back({reg_wr_addr, reg_wr_data});
    if (sda_oe) oe_seen = 1'b1;
  end

  initial begin
    #900us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Reference model: register array and auto-incrementing pointer.
  logic [7:0] mdl_mem [256];
  logic [7:0] mdl_ptr;

  function automatic void mdl_reset();
    for (int i = 0; i < 256; i++) mdl_mem[i] = (i == 10) ? 8'h76 : (i == 11) ? 8'h73 : 8'h00;
    mdl_ptr = 8'h00;
  endfunction

  function automatic void mdl_store(input logic [7:0] a, input logic [7:0] d);
    if (a != 8'h0A && a != 8'h0B) mdl_mem[a] = d;
  endfunction

  // Bus primitives: SDA only moves while SCL is low, 2 clk after the fall.
  task automatic phase();
    repeat (HALF) @(negedge clk);
  endtask

  task automatic bus_start();
    repeat (2) @(negedge clk);
    sda_m = 1'b1;
    phase();
    scl_m = 1'b1;
    phase();
    sda_m = 1'b0;
    phase();
    scl_m = 1'b0;
  endtask

  task automatic bus_stop();
    repeat (2) @(negedge clk);
    sda_m = 1'b0;
    phase();
    scl_m = 1'b1;
    phase();
    sda_m = 1'b1;
    phase();
  endtask

  task automatic send_bit(input logic b);
    repeat (2) @(negedge clk);
    sda_m = b;
    repeat (HALF - 2) @(negedge clk);
    scl_m = 1'b1;
    phase();
    scl_m = 1'b0;
  endtask

  task automatic recv_bit(output logic b);
    repeat (2) @(negedge clk);
    sda_m = 1'b1;
    repeat (HALF - 2) @(negedge clk);
    scl_m = 1'b1;
    repeat (HALF / 2) @(negedge clk);
    b = sda_bus;
    repeat (HALF - HALF / 2) @(negedge clk);
    scl_m = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(b);
    ack = ~b;
  endtask

  task automatic read_byte(output logic [7:0] d, input logic nack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    send_bit(nack);
  endtask

  task automatic dbg_read(input logic [7:0] a, output logic [7:0] d);
    dbg_addr = a;
    #1;
    d = dbg_data;
  endtask

  task automatic txn_write(input logic [7:0] dev, input logic [7:0] sub, input logic [7:0] data [4],
                           input int n, input string tag);
    logic ack, hit;
    logic [15:0] exp_q[$];
    hit = (dev == 8'h42);
    wr_log.delete();
    oe_seen = 1'b0;
    bus_start();
    write_byte(dev, ack);
    check({tag, " addr ack"}, ack, hit);
    check({tag, " busy"}, busy, hit);
    write_byte(sub, ack);
    check({tag, " sub ack"}, ack, hit);
    if (hit) mdl_ptr = sub;
    for (int k = 0; k < n; k++) begin
      write_byte(data[k], ack);
      check({tag, " data ack"}, ack, hit);
      if (hit) begin
        exp_q.push_back({mdl_ptr, data[k]});
        mdl_store(mdl_ptr, data[k]);
        mdl_ptr++;
      end
    end
    bus_stop();
    check({tag, " busy after stop"}, busy, 0);
    check({tag, " sda_oe activity"}, oe_seen, hit);
    check({tag, " write count"}, wr_log.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < wr_log.size(); k++)
      check({tag, " write addr/data"}, wr_log[k], exp_q[k]);
  endtask

  task automatic txn_read(input logic do_sub, input logic [7:0] sub, input logic use_stop, input int n,
                          input string tag, output logic [7:0] last);
    logic ack;
    logic [7:0] d;
    last = 8'h00;
    bus_start();
    if (do_sub) begin
      write_byte(8'h42, ack);
      check({tag, " wr addr ack"}, ack, 1);
      write_byte(sub, ack);
      check({tag, " sub ack"}, ack, 1);
      mdl_ptr = sub;
      if (use_stop) bus_stop();
      bus_start();
    end
    write_byte(8'h43, ack);
    check({tag, " rd addr ack"}, ack, 1);
    for (int k = 0; k < n; k++) begin
      read_byte(d, k == n - 1);
      check({tag, " rdata"}, d, mdl_mem[mdl_ptr]);
      mdl_ptr++;
      last = d;
    end
    bus_stop();
    check({tag, " busy after stop"}, busy, 0);
  endtask

  typedef struct {
    logic [7:0] dev;
    logic [7:0] sub;
    logic [7:0] data;
    logic       exp_ack;
    logic [7:0] exp_dbg;
  } vec_t;

  vec_t vecs [7];

  initial begin
    vec_t       v;
    logic       ack, b;
    logic [7:0] d;
    logic [7:0] dq [4];
    int         kind, n;
    logic [7:0] sub, dev;

    vecs[0] = '{8'h42, 8'h12, 8'h80, 1'b1, 8'h80};
    vecs[1] = '{8'h42, 8'h0B, 8'h55, 1'b1, 8'h73};
    vecs[2] = '{8'h60, 8'h33, 8'h99, 1'b0, 8'h00};
    vecs[3] = '{8'h42, 8'h0A, 8'hFF, 1'b1, 8'h76};
    vecs[4] = '{8'h42, 8'h00, 8'hA5, 1'b1, 8'hA5};
    vecs[5] = '{8'h40, 8'h12, 8'h11, 1'b0, 8'h80};
    vecs[6] = '{8'h42, 8'hFF, 8'h5A, 1'b1, 8'h5A};

    mdl_reset();
    dbg_addr = 8'h00;
    repeat (4) @(negedge clk);
    reset_ = 1'b0;
    repeat (2) @(negedge clk);

    check("reset sda_oe", sda_oe, 0);
    check("reset reg_wr_en", reg_wr_en, 0);
    check("reset reg_wr_addr", reg_wr_addr, 0);
    check("reset reg_wr_data", reg_wr_data, 0);
    check("reset busy", busy, 0);
    dbg_read(8'h0A, d); check("reset PID", d, 8'h76);
    dbg_read(8'h0B, d); check("reset VER", d, 8'h73);
    dbg_read(8'h12, d); check("reset reg12", d, 8'h00);

    for (int i = 0; i < 7; i++) begin
      v = vecs[i];
      wr_log.delete();
      oe_seen = 1'b0;
      bus_start();
      write_byte(v.dev, ack);
      check($sformatf("vec%0d addr ack", i), ack, v.exp_ack);
      check($sformatf("vec%0d busy", i), busy, v.exp_ack);
      write_byte(v.sub, ack);
      write_byte(v.data, ack);
      check($sformatf("vec%0d data ack", i), ack, v.exp_ack);
      bus_stop();
      check($sformatf("vec%0d busy after stop", i), busy, 0);
      check($sformatf("vec%0d sda_oe activity", i), oe_seen, v.exp_ack);
      check($sformatf("vec%0d write count", i), wr_log.size(), v.exp_ack);
      if (v.exp_ack && wr_log.size() == 1)
        check($sformatf("vec%0d write addr/data", i), wr_log[0], {v.sub, v.data});
      dbg_read(v.sub, d);
      check($sformatf("vec%0d dbg_data", i), d, v.exp_dbg);
      if (v.exp_ack) begin
        mdl_store(v.sub, v.data);
        mdl_ptr = v.sub + 8'd1;
      end
    end

    // Two-phase read of PID with STOP between phases, then a pointer-only read.
    txn_read(1'b1, 8'h0A, 1'b1, 1, "pid read", d);
    check("pid read value", d, 8'h76);
    txn_read(1'b0, 8'h00, 1'b0, 1, "ptr kept read", d);
    check("ptr kept value", d, 8'h73);

    // Burst write wrapping past 8'hFF.
    dq = '{8'h11, 8'h22, 8'h33, 8'h00};
    txn_write(8'h42, 8'hFE, dq, 3, "burst");
    check("burst pulses", wr_log.size(), 3);
    dbg_read(8'hFE, d); check("burst FE", d, 8'h11);
    dbg_read(8'hFF, d); check("burst FF", d, 8'h22);
    dbg_read(8'h00, d); check("burst 00", d, 8'h33);

    for (int t = 0; t < 16; t++) begin
      kind = $urandom_range(0, 3);
      n    = $urandom_range(1, 3);
      sub  = ($urandom_range(0, 5) == 0) ? (8'h0A + 8'($urandom_range(0, 1))) : 8'($urandom);
      for (int k = 0; k < 4; k++) dq[k] = 8'($urandom);
      case (kind)
        0: txn_write(8'h42, sub, dq, n, "rand wr");
        1: txn_read(1'b1, sub, 1'($urandom_range(0, 1)), n, "rand rd", d);
        2: txn_read(1'b0, sub, 1'b0, n, "rand rd ptr", d);
        default: begin
          dev = 8'($urandom);
          if (dev[7:1] == 7'h21) dev[7:1] = 7'h22;
          txn_write(dev, sub, dq, n, "rand miss");
        end
      endcase
      sub = 8'($urandom);
      dbg_read(sub, d);
      check("rand dbg_data", d, mdl_mem[sub]);
    end

    // Reset while the responder is driving a 0 bit of a read.
    dq = '{8'h80, 8'h00, 8'h00, 8'h00};
    txn_write(8'h42, 8'h12, dq, 1, "pre-reset");
    bus_start();
    write_byte(8'h42, ack);
    write_byte(8'h12, ack);
    bus_start();
    write_byte(8'h43, ack);
    check("rst rd addr ack", ack, 1);
    recv_bit(b);
    check("rst bit7", b, 1);
    repeat (6) @(negedge clk);
    check("rst sda_oe before", sda_oe, 1);
    reset_ = 1'b1;
    #1;
    check("rst sda_oe async", sda_oe, 0);
    check("rst busy async", busy, 0);
    repeat (3) @(negedge clk);
    dbg_read(8'h12, d); check("rst reg12 cleared", d, 8'h00);
    dbg_read(8'h0A, d); check("rst PID restored", d, 8'h76);
    check("rst reg_wr_addr", reg_wr_addr, 0);
    reset_ = 1'b0;
    mdl_reset();
    sda_m = 1'b1;
    scl_m = 1'b1;
    phase();
    txn_read(1'b0, 8'h00, 1'b0, 1, "post-rst rd", d);
    check("post-rst ptr zero read", d, 8'h00);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
